// File: rtl/w_stage_regfile.sv
// w_stage_regfile: MIPS general-purpose register file fed by the W stage.
// Two combinational read ports for the D stage with an internal write-first
// bypass, so a same-cycle W write / D read of one register needs no external
// forwarding. Register $0 is hard-wired to zero.
// Optional simulation trace of committing writes: define GRF_TRACE_EN.
module w_stage_regfile #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int REG_COUNT = 32   // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       w_pc,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];

    // A write only commits when not in reset and not aimed at $0.
    logic commit;
    assign commit = !reset && we && (wa != '0);

    // Next-state array: reset clears everything and wins over the write.
    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs_d[i] = '0;
        end else if (commit) begin
            regs_d[wa] = wd;
        end
        // $0 is never stored; keep its flop pinned so it can never go X.
        regs_d[0] = '0;
    end

    // Array state register.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read port 1: reset, then $0, then write-first bypass, then array.
    always_comb begin
        rd1 = regs_q[ra1];
        if (reset)                   rd1 = '0;
        else if (ra1 == '0)          rd1 = '0;
        else if (we && (wa == ra1))  rd1 = wd;
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2 = regs_q[ra2];
        if (reset)                   rd2 = '0;
        else if (ra2 == '0)          rd2 = '0;
        else if (we && (wa == ra2))  rd2 = wd;
    end

`ifdef GRF_TRACE_EN
    // Simulation trace: one line per committing write, none for dropped ones.
    always_ff @(posedge clk) begin
        if (commit) $display("%d@%h: $%d <= %h", $time, w_pc, wa, wd);
    end
`else
    // w_pc only feeds the trace; fold it away when the trace is compiled out.
    logic unused_pc;
    assign unused_pc = ^w_pc;
`endif

endmodule

// File: tb/tb_w_stage_regfile.sv
// Bench for w_stage_regfile: directed steps then randomized traffic checked
// against an array-based reference model of the register file.
module tb_w_stage_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] w_pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    w_stage_regfile #(.DATA_W(32), .ADDR_W(5), .REG_COUNT(32)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .w_pc(w_pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        reset = r; we = w; wa = a; wd = d; ra1 = a1; ra2 = a2;
        #1;
    endtask

    // Architectural read rule, straight from the register-file semantics.
    function automatic logic [31:0] mdl_read(input logic [4:0] ra);
        if (reset)             return 32'h0;
        if (ra == 5'd0)        return 32'h0;
        if (we && wa == ra)    return wd;
        return mdl[ra];
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            mdl[wa] = wd;
        end
        w_pc = w_pc + 32'd4;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        w_pc = 32'h00003000;

        // 1. reset with a pending write: outputs forced to zero, write dropped
        drive(1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        chk("rst_rd1_forced", rd1, 32'h0);
        chk("rst_rd2_forced", rd2, 32'h0);
        tick();
        tick();
        drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd31);
        chk("rst_r5", rd1, 32'h0);
        chk("rst_r31", rd2, 32'h0);

        // 2. basic write then read
        drive(0, 1, 5'd8, 32'h12345678, 5'd0, 5'd0);
        tick();
        drive(0, 0, 5'd8, 32'h0, 5'd8, 5'd9);
        chk("wr_r8", rd1, 32'h12345678);
        chk("wr_r9", rd2, 32'h0);

        // 3. bypass, both ports on the register being written
        drive(0, 1, 5'd3, 32'h00000001, 5'd0, 5'd0);
        tick();
        drive(0, 1, 5'd3, 32'hCAFE0000, 5'd3, 5'd3);
        chk("byp_rd1", rd1, 32'hCAFE0000);
        chk("byp_rd2", rd2, 32'hCAFE0000);
        tick();
        drive(0, 0, 5'd3, 32'h0, 5'd3, 5'd8);
        chk("byp_after", rd1, 32'hCAFE0000);
        chk("byp_r8_kept", rd2, 32'h12345678);

        // 4. $0 protection
        drive(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk("r0_same_cyc", rd1, 32'h0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("r0_after", rd1, 32'h0);

        // 5. disabled write leaves the array alone
        drive(0, 1, 5'd10, 32'hA5A5A5A5, 5'd0, 5'd0);
        tick();
        drive(0, 0, 5'd10, 32'h0, 5'd10, 5'd10);
        chk("we0_rd1", rd1, 32'hA5A5A5A5);
        tick();
        chk("we0_after", rd1, 32'hA5A5A5A5);

        // 6. reset in the middle of a write stream
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 5'(i), 32'(i), 5'd0, 5'd0);
            tick();
        end
        drive(0, 0, 5'd0, 32'h0, 5'd4, 5'd1);
        chk("stream_r4", rd1, 32'h4);
        chk("stream_r1", rd2, 32'h1);
        drive(1, 1, 5'd5, 32'h5, 5'd0, 5'd0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 5'd0, 32'h0, 5'(i), 5'd10);
            chk($sformatf("midrst_r%0d", i), rd1, 32'h0);
        end
        chk("midrst_r10", rd2, 32'h0);
        drive(0, 1, 5'd2, 32'h77, 5'd0, 5'd0);
        tick();
        drive(0, 0, 5'd0, 32'h0, 5'd2, 5'd2);
        chk("post_rst_wr", rd1, 32'h77);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic r, w;
            logic [4:0] a, a1, a2;
            logic [31:0] d;
            r  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 3) != 0);
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            drive(r, w, a, d, a1, a2);
            chk($sformatf("rnd%0d_rd1", n), rd1, mdl_read(a1));
            chk($sformatf("rnd%0d_rd2", n), rd2, mdl_read(a2));
            tick();
        end

        // Final sweep of the whole array
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            chk($sformatf("sweep_r%0d", i), rd1, mdl_read(5'(i)));
            chk($sformatf("sweep_r%0d", 31 - i), rd2, mdl_read(5'(31 - i)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
